mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive D$ grants while an I$ request waits (used only when MEM_ARB_ANTI_STARVE_EN is defined).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dcache_req_valid_miss  input  1  single-cycle D$ miss request pulse.
REQ-005 dcache_req_info_miss  input  memory_request_t  D$ request payload (addr, data, is_store); sampled only with valid.
REQ-006 icache_req_valid_miss  input  1  single-cycle I$ miss request pulse.
REQ-007 icache_req_info_miss  input  memory_request_t  I$ request payload.
REQ-008 mm_req_valid  output  1  request to main memory, held high until the response.
REQ-009 mm_req_info  output  memory_request_t  granted request payload, stable while mm_req_valid is high.
REQ-010 mm_rsp_valid  input  1  main-memory completion pulse (load data or store ack).
REQ-011 mm_rsp_data  input  DCACHE_LINE_WIDTH  main-memory line data.
REQ-012 rsp_valid_miss  output  1  single-cycle response pulse to the caches.
REQ-013 rsp_cache_id  output  1  response target: 0 = I$, 1 = D$.
REQ-014 rsp_data_miss  output  DCACHE_LINE_WIDTH  response line data.
REQ-015 err_dup_req  output  1  pulses when a request arrives while the same cache already has one pending.

Function
REQ-016 Each cache has one pending slot; a valid pulse at cycle N sets the slot and stores its payload, visible from N+1.
REQ-017 A valid pulse while the slot is already pending is dropped, the slot is unchanged, and err_dup_req pulses at N+1.
REQ-018 FSM states: IDLE, WAIT, RSP.
REQ-019 IDLE: with any slot pending, grant one (REQ-020), latch its payload and id, and go to WAIT; otherwise stay in IDLE.
REQ-020 Grant policy: D$ wins when both are pending; I$ wins when only I$ is pending. A granted transaction is never preempted.
REQ-021 WAIT: mm_req_valid=1 and mm_req_info=latched payload; on mm_rsp_valid, capture mm_rsp_data and go to RSP.
REQ-022 RSP: rsp_valid_miss=1 for exactly one cycle with the latched id and data; clear the granted slot; go to IDLE.
REQ-023 Latency: request pulse at N, mm_req_valid from N+2; mm_rsp_valid at M, rsp_valid_miss at M+1; next grant possible at M+2.
REQ-024 Stores complete identically; rsp_data_miss carries mm_rsp_data unchanged, and the caches ignore it.
REQ-025 mm_rsp_valid outside WAIT is ignored.
REQ-026 A new pulse from the non-granted cache during WAIT or RSP is captured normally.
REQ-027 rsp_cache_id and rsp_data_miss hold their last values when rsp_valid_miss is 0.

Reset
REQ-028 Reset puts the FSM in IDLE and clears both slots, the starvation counter and all latches.
REQ-029 During reset: mm_req_valid=0, rsp_valid_miss=0, err_dup_req=0, rsp_cache_id=0, rsp_data_miss=0, mm_req_info=0.
REQ-030 Reset asserted in WAIT or RSP abandons the transaction silently; a later mm_rsp_valid is ignored per REQ-025.

Configuration
REQ-031 Macro MEM_ARB_ANTI_STARVE_EN defined: a counter increments on each D$ grant made while I$ is pending and clears on each I$ grant.
REQ-032 With MEM_ARB_ANTI_STARVE_EN defined, when the counter equals STARVE_LIMIT the next grant goes to I$ even if D$ is pending.
REQ-033 Macro MEM_ARB_ANTI_STARVE_EN undefined: strict D$ priority, and no counter logic is synthesized.

Structure
REQ-034 memory_request_t, the mem_arb_state_t enum and the DCACHE_LINE_WIDTH define live in the shared soc package/header.
REQ-035 One sub-module, mem_arb_slot (valid flag plus payload register, set/clear ports, dup-detect output), is instantiated once per cache.

Verification
REQ-036 D$ load addr 0x40 at cycle 2, memory responds at cycle 10 -> mm_req_valid high in cycles 4-10, rsp_valid_miss=1 with id=1 at cycle 11.
REQ-037 I$ and D$ pulse in the same cycle -> D$ served first, then I$; two rsp_valid_miss pulses with ids 1 then 0.
REQ-038 I$ granted, D$ pulses during WAIT -> I$ completes unpreempted, then D$ is granted at the next IDLE.
REQ-039 D$ pulses twice without a response in between -> err_dup_req single pulse, original payload addr retained on mm_req_info.
REQ-040 reset asserted mid-WAIT, mm_rsp_valid pulses afterwards -> no rsp_valid_miss, FSM stays IDLE.
REQ-041 With MEM_ARB_ANTI_STARVE_EN and STARVE_LIMIT=2, I$ pending under continuous D$ traffic -> I$ granted after exactly 2 D$ grants.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types for the I$/D$ main-memory arbiter: cache line
//               width, request payload struct, arbiter state enum and
//               cache id constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int DCACHE_LINE_WIDTH = 64;
  localparam int ADDR_WIDTH        = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         is_store;
  } memory_request_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RSP  = 2'd2
  } mem_arb_state_t;

  // Response target encoding on rsp_cache_id
  localparam logic c_cache_id_i = 1'b0;
  localparam logic c_cache_id_d = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_slot.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_slot
// Description : One pending-request slot: valid flag plus payload register.
//               A set while already pending is dropped and flagged on o_dup
//               one cycle later. A set arriving in the same cycle as the
//               clear is accepted, because the slot is being freed then.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  memory_request_t i_info,
  input  logic            i_clr,
  output logic            o_valid,
  output memory_request_t o_info,
  output logic            o_dup
);

  logic            r_valid;
  memory_request_t r_info;
  logic            r_dup;
  logic            w_accept;

  assign w_accept = i_set & (~r_valid | i_clr);

  // Slot occupancy, payload capture and duplicate-request flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_info  <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_dup <= i_set & r_valid & ~i_clr;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_info  <= i_info;
      end else if (i_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_info  = r_info;
  assign o_dup   = r_dup;

endmodule : mem_arb_slot
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates single-outstanding I$ and D$ miss requests onto
//               one main-memory port. D$ has priority; one transaction is in
//               flight at a time and is never preempted.
//               Optional feature macro: MEM_ARB_ANTI_STARVE_EN - after
//               STARVE_LIMIT consecutive D$ grants with I$ waiting, the next
//               grant goes to I$.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         dcache_req_valid_miss,
  input  memory_request_t              dcache_req_info_miss,
  input  logic                         icache_req_valid_miss,
  input  memory_request_t              icache_req_info_miss,
  output logic                         mm_req_valid,
  output memory_request_t              mm_req_info,
  input  logic                         mm_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0] mm_rsp_data,
  output logic                         rsp_valid_miss,
  output logic                         rsp_cache_id,
  output logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss,
  output logic                         err_dup_req
);

  mem_arb_state_t               r_state;
  mem_arb_state_t               w_next_state;
  logic                         r_gnt_id;
  memory_request_t              r_req_info;
  logic                         r_rsp_id;
  logic [DCACHE_LINE_WIDTH-1:0] r_rsp_data;

  logic            w_d_valid;
  logic            w_i_valid;
  memory_request_t w_d_info;
  memory_request_t w_i_info;
  logic            w_d_dup;
  logic            w_i_dup;
  logic            w_d_clr;
  logic            w_i_clr;
  logic            w_any_pending;
  logic            w_grant_en;
  logic            w_grant_d;
  logic            w_force_i;

  // A limit below one would never let a D$ grant through; nothing is built.
  generate
    if (STARVE_LIMIT < 1) begin : g_limit_unsupported
    end
  endgenerate

  mem_arb_slot u_dslot (
    .clk     (clock),
    .rst     (reset),
    .i_set   (dcache_req_valid_miss),
    .i_info  (dcache_req_info_miss),
    .i_clr   (w_d_clr),
    .o_valid (w_d_valid),
    .o_info  (w_d_info),
    .o_dup   (w_d_dup)
  );

  mem_arb_slot u_islot (
    .clk     (clock),
    .rst     (reset),
    .i_set   (icache_req_valid_miss),
    .i_info  (icache_req_info_miss),
    .i_clr   (w_i_clr),
    .o_valid (w_i_valid),
    .o_info  (w_i_info),
    .o_dup   (w_i_dup)
  );

  assign w_any_pending = w_d_valid | w_i_valid;
  assign w_grant_en    = (r_state == ST_IDLE) & w_any_pending;
  assign w_grant_d     = w_d_valid & ~w_force_i;

`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  logic [c_cnt_w-1:0] r_starve_cnt;

  assign w_force_i = w_i_valid & (r_starve_cnt == c_limit);

  // Counts D$ grants made over a waiting I$; any I$ grant restarts the count.
  // At the limit I$ wins, so the count never exceeds STARVE_LIMIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_en) begin
      if (!w_grant_d) begin
        r_starve_cnt <= '0;
      end else if (w_i_valid) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one transaction from grant through response
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_pending) w_next_state = ST_WAIT;
      ST_WAIT: if (mm_rsp_valid)  w_next_state = ST_RSP;
      ST_RSP:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: memory request in WAIT, response pulse and slot release in RSP
  always_comb begin
    mm_req_valid   = 1'b0;
    rsp_valid_miss = 1'b0;
    w_d_clr        = 1'b0;
    w_i_clr        = 1'b0;
    case (r_state)
      ST_WAIT: mm_req_valid = 1'b1;
      ST_RSP: begin
        rsp_valid_miss = 1'b1;
        w_d_clr        = (r_gnt_id == c_cache_id_d);
        w_i_clr        = (r_gnt_id == c_cache_id_i);
      end
      default: ;
    endcase
  end

  // Grant and response latches; response fields only change on a new response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt_id   <= c_cache_id_i;
      r_req_info <= '0;
      r_rsp_id   <= c_cache_id_i;
      r_rsp_data <= '0;
    end else begin
      if (w_grant_en) begin
        r_gnt_id   <= w_grant_d ? c_cache_id_d : c_cache_id_i;
        r_req_info <= w_grant_d ? w_d_info : w_i_info;
      end
      if ((r_state == ST_WAIT) && mm_rsp_valid) begin
        r_rsp_id   <= r_gnt_id;
        r_rsp_data <= mm_rsp_data;
      end
    end
  end

  assign mm_req_info   = r_req_info;
  assign rsp_cache_id  = r_rsp_id;
  assign rsp_data_miss = r_rsp_data;
  assign err_dup_req   = w_d_dup | w_i_dup;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model (pending flags, payloads, starvation count) predicts
//               grant order, payloads, duplicate errors and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dv = 1'b0;
  logic iv = 1'b0;
  logic mrv = 1'b0;
  memory_request_t dinfo = '0;
  memory_request_t iinfo = '0;
  logic [DCACHE_LINE_WIDTH-1:0] mrdata = '0;

  logic                         mreq_v;
  memory_request_t              mreq_info;
  logic                         rv;
  logic                         rid;
  logic [DCACHE_LINE_WIDTH-1:0] rdata;
  logic                         dup;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: index 1 = D$, index 0 = I$
  bit              m_pend [2];
  memory_request_t m_pay  [2];
  int              m_starve = 0;
  int              grant_log [$];

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .dcache_req_valid_miss (dv),
    .dcache_req_info_miss  (dinfo),
    .icache_req_valid_miss (iv),
    .icache_req_info_miss  (iinfo),
    .mm_req_valid          (mreq_v),
    .mm_req_info           (mreq_info),
    .mm_rsp_valid          (mrv),
    .mm_rsp_data           (mrdata),
    .rsp_valid_miss        (rv),
    .rsp_cache_id          (rid),
    .rsp_data_miss         (rdata),
    .err_dup_req           (dup)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic memory_request_t rand_req(input bit st);
    memory_request_t r;
    r.addr     = $urandom;
    r.data     = {$urandom, $urandom};
    r.is_store = st;
    return r;
  endfunction

  function automatic int model_pick();
    bit starve_i;
    starve_i = 1'b0;
`ifdef MEM_ARB_ANTI_STARVE_EN
    starve_i = m_pend[0] && (m_starve >= LIMIT);
`endif
    if (m_pend[1] && !starve_i) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    m_starve  = 0;
  endtask

  // Drive one-cycle request pulses and update the model's pending slots
  task automatic pulse(input bit do_d, input bit do_i, input memory_request_t rd,
                       input memory_request_t ri, output bit exp_dup);
    exp_dup = 1'b0;
    if (do_d) begin
      dv = 1'b1; dinfo = rd;
      if (m_pend[1]) exp_dup = 1'b1;
      else begin m_pend[1] = 1'b1; m_pay[1] = rd; end
    end
    if (do_i) begin
      iv = 1'b1; iinfo = ri;
      if (m_pend[0]) exp_dup = 1'b1;
      else begin m_pend[0] = 1'b1; m_pay[0] = ri; end
    end
    tick();
    dv = 1'b0;
    iv = 1'b0;
  endtask

  // Act as main memory for one transaction, with optional injected pulses
  task automatic serve(input int delay, input bit inj_same, input bit inj_other, input bit stream_d);
    int id;
    int w;
    bit ed;
    memory_request_t r;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    id = model_pick();
    if (id == 1 && m_pend[0]) m_starve++;
    else if (id == 0) m_starve = 0;
    w = 0;
    while (mreq_v !== 1'b1 && w < 20) begin tick(); w++; end
    n_total++; if (mreq_v !== 1'b1) $display("FAIL grant_timeout: mm_req_valid=%b required 1", mreq_v); else n_pass++;
    n_total++; if (mreq_info !== m_pay[id]) $display("FAIL grant_info: addr=%h st=%b required addr=%h st=%b (cache %0d)", mreq_info.addr, mreq_info.is_store, m_pay[id].addr, m_pay[id].is_store, id); else n_pass++;
    if (inj_same) begin
      r = rand_req(1'($urandom % 2));
      pulse(id == 1, id == 0, r, r, ed);
      n_total++; if (dup !== ed) $display("FAIL dup_same: err_dup_req=%b required %b", dup, ed); else n_pass++;
      n_total++; if (mreq_info !== m_pay[id]) $display("FAIL dup_keeps_info: addr=%h required %h", mreq_info.addr, m_pay[id].addr); else n_pass++;
    end
    if (inj_other) begin
      r = rand_req(1'($urandom % 2));
      pulse(id == 0, id == 1, r, r, ed);
      n_total++; if (dup !== ed) $display("FAIL dup_other: err_dup_req=%b required %b", dup, ed); else n_pass++;
    end
    for (int k = 0; k < delay; k++) tick();
    n_total++; if (mreq_v !== 1'b1 || mreq_info !== m_pay[id]) $display("FAIL req_hold: valid=%b addr=%h required 1 addr=%h", mreq_v, mreq_info.addr, m_pay[id].addr); else n_pass++;
    data = {$urandom, $urandom};
    mrv = 1'b1; mrdata = data;
    tick();
    mrv = 1'b0;
    n_total++; if (rv !== 1'b1 || rid !== id[0] || rdata !== data) $display("FAIL rsp: valid=%b id=%b data=%h required 1 id=%0d data=%h", rv, rid, rdata, id, data); else n_pass++;
    grant_log.push_back(int'(rid));
    m_pend[id] = 1'b0;
    ed = 1'b0;
    if (stream_d) pulse(1'b1, 1'b0, rand_req(1'b0), rand_req(1'b0), ed);
    else tick();
    n_total++; if (rv !== 1'b0 || mreq_v !== 1'b0 || rid !== id[0] || rdata !== data || dup !== ed) $display("FAIL rsp_after: valid=%b req=%b id=%b data=%h dup=%b required 0 0 id=%0d data=%h dup=%b", rv, mreq_v, rid, rdata, dup, id, data, ed); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; dv = 1'b0; iv = 1'b0; mrv = 1'b0;
    tick(); tick();
    n_total++; if (mreq_v !== 1'b0) $display("FAIL reset_req_valid: %b required 0", mreq_v); else n_pass++;
    n_total++; if (rv !== 1'b0) $display("FAIL reset_rsp_valid: %b required 0", rv); else n_pass++;
    n_total++; if (dup !== 1'b0) $display("FAIL reset_dup: %b required 0", dup); else n_pass++;
    n_total++; if (rid !== 1'b0) $display("FAIL reset_id: %b required 0", rid); else n_pass++;
    n_total++; if (rdata !== '0) $display("FAIL reset_data: %h required 0", rdata); else n_pass++;
    n_total++; if (mreq_info !== '0) $display("FAIL reset_info: %h required 0", mreq_info); else n_pass++;
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  // D$ load at addr 0x40 at cycle N, memory answers at N+8
  task automatic test_basic_load();
    memory_request_t r;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    bit ed;
    r = rand_req(1'b0);
    r.addr = 32'h40;
    pulse(1'b1, 1'b0, r, r, ed);
    n_total++; if (mreq_v !== 1'b0 || dup !== ed) $display("FAIL load_n1: req=%b dup=%b required 0 %b", mreq_v, dup, ed); else n_pass++;
    tick();
    n_total++; if (mreq_v !== 1'b1 || mreq_info.addr !== 32'h40) $display("FAIL load_n2: req=%b addr=%h required 1 addr=40", mreq_v, mreq_info.addr); else n_pass++;
    for (int k = 0; k < 6; k++) tick();
    n_total++; if (mreq_v !== 1'b1 || rv !== 1'b0) $display("FAIL load_n8: req=%b rsp=%b required 1 0", mreq_v, rv); else n_pass++;
    data = {$urandom, $urandom};
    mrv = 1'b1; mrdata = data;
    tick();
    mrv = 1'b0;
    n_total++; if (rv !== 1'b1 || rid !== 1'b1 || rdata !== data || mreq_v !== 1'b0) $display("FAIL load_rsp: valid=%b id=%b data=%h req=%b required 1 1 %h 0", rv, rid, rdata, mreq_v, data); else n_pass++;
    m_pend[1] = 1'b0;
    tick();
    n_total++; if (rv !== 1'b0 || rid !== 1'b1 || rdata !== data) $display("FAIL load_hold: valid=%b id=%b data=%h required 0 1 %h", rv, rid, rdata, data); else n_pass++;
  endtask

  task automatic check_order(input string tag, input int base, input int exp_seq [4], input int n);
    n_total++; if (grant_log.size() != base + n) $display("FAIL %s_count: %0d responses required %0d", tag, grant_log.size() - base, n); else n_pass++;
    for (int k = 0; k < n; k++) begin
      if (base + k < grant_log.size()) begin
        n_total++; if (grant_log[base + k] != exp_seq[k]) $display("FAIL %s_order[%0d]: id=%0d required %0d", tag, k, grant_log[base + k], exp_seq[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ed;
    int base;
    int exp_seq [4];
    exp_seq = '{1, 0, 0, 0};
    base = grant_log.size();
    pulse(1'b1, 1'b1, rand_req(1'b0), rand_req(1'b0), ed);
    n_total++; if (dup !== ed) $display("FAIL simul_dup: %b required %b", dup, ed); else n_pass++;
    serve(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    serve(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    check_order("simul", base, exp_seq, 2);
  endtask

  task automatic test_no_preempt();
    bit ed;
    int base;
    int exp_seq [4];
    exp_seq = '{0, 1, 0, 0};
    base = grant_log.size();
    pulse(1'b0, 1'b1, rand_req(1'b0), rand_req(1'b0), ed);
    serve(3, 1'b0, 1'b1, 1'b0);
    serve(1, 1'b0, 1'b0, 1'b0);
    check_order("nopreempt", base, exp_seq, 2);
  endtask

  task automatic test_dup();
    bit ed;
    pulse(1'b1, 1'b0, rand_req(1'b1), rand_req(1'b0), ed);
    serve(2, 1'b1, 1'b0, 1'b0);
    n_total++; if (dup !== 1'b0) $display("FAIL dup_single_pulse: %b required 0", dup); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit ed;
    pulse(1'b1, 1'b0, rand_req(1'b0), rand_req(1'b0), ed);
    tick();
    n_total++; if (mreq_v !== 1'b1) $display("FAIL midwait_req: %b required 1", mreq_v); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (mreq_v !== 1'b0 || rv !== 1'b0 || rid !== 1'b0 || rdata !== '0 || mreq_info !== '0) $display("FAIL midwait_reset: req=%b rsp=%b id=%b data=%h info=%h required all 0", mreq_v, rv, rid, rdata, mreq_info); else n_pass++;
    reset = 1'b0;
    model_clear();
    mrv = 1'b1; mrdata = {$urandom, $urandom};
    tick();
    mrv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (rv !== 1'b0 || mreq_v !== 1'b0) $display("FAIL midwait_ignore[%0d]: rsp=%b req=%b required 0 0", k, rv, mreq_v); else n_pass++;
      tick();
    end
  endtask

  // I$ waits while D$ re-requests in every response cycle
  task automatic test_stream();
    bit ed;
    int base;
    int guard;
    int exp_seq [4];
`ifdef MEM_ARB_ANTI_STARVE_EN
    exp_seq = '{1, 1, 0, 1};
`else
    exp_seq = '{1, 1, 1, 0};
`endif
    base = grant_log.size();
    pulse(1'b1, 1'b1, rand_req(1'b0), rand_req(1'b0), ed);
    serve(1, 1'b0, 1'b0, 1'b1);
    serve(1, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while ((m_pend[0] || m_pend[1]) && guard < 4) begin
      serve(1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check_order("stream", base, exp_seq, 4);
  endtask

  task automatic test_random();
    bit ed;
    int mask;
    int guard;
    for (int rnd = 0; rnd < 30; rnd++) begin
      mask = int'($urandom_range(1, 3));
      pulse(mask[1], mask[0], rand_req(1'($urandom % 2)), rand_req(1'($urandom % 2)), ed);
      n_total++; if (dup !== ed) $display("FAIL rand_dup[%0d]: %b required %b", rnd, dup, ed); else n_pass++;
      guard = 0;
      while ((m_pend[0] || m_pend[1]) && guard < 8) begin
        serve(int'($urandom_range(0, 4)), 1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) == 0);
        guard++;
      end
      if (m_pend[0] || m_pend[1]) begin
        // Drain without further injections so the next round starts empty
        while (m_pend[0] || m_pend[1]) serve(0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_simultaneous();
    test_no_preempt();
    test_dup();
    test_reset_mid_wait();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
